// File: rtl/aes_tcdm_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_tcdm_resp_package
// Description : Shared constants, response pipeline entry type and the
//               byte-enable merge helper for the AES TCDM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_tcdm_resp_package;

    // Read data returned for misaligned or out-of-range accesses
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // One slot of the response delay line
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_entry_t;

    // Byte-lane merge: lanes with be=1 take the new data, others keep the old word
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_tcdm_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_tcdm_resp_pipe
// Description : LATENCY-deep shift register of response entries. Reset
//               empties it asynchronously, flush empties it on the clock edge
//               (including the entry being captured on that edge).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_tcdm_resp_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o
);
    import aes_tcdm_resp_package::*;

    resp_entry_t [LATENCY-1:0] stage_q;

    // Shift responses one stage per cycle; flush drops everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else if (flush_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= '{valid: in_valid_i, data: in_data_i};
            for (int s = 1; s < LATENCY; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign out_valid_o = stage_q[LATENCY-1].valid;
    // Data is forced to zero whenever no response is being presented
    assign out_data_o  = stage_q[LATENCY-1].valid ? stage_q[LATENCY-1].data : 32'h0;

endmodule
`default_nettype wire

// File: rtl/aes_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module      : aes_tcdm_responder
// Description : Word-addressed TCDM slave memory for the AES HWPE streamer.
//               Fixed-latency in-order responses, programmable grant stalls,
//               backdoor debug port, access counters and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_tcdm_responder #(
    parameter int          DEPTH            = 1024,
    parameter logic [31:0] BASE_ADDR        = 32'h1C00_0000,
    parameter int          LATENCY          = 1,
    parameter int          GNT_STALL_PERIOD = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     tcdm_req,
    output logic                     tcdm_gnt,
    input  logic [31:0]              tcdm_add,
    input  logic                     tcdm_wen,
    input  logic [3:0]               tcdm_be,
    input  logic [31:0]              tcdm_data,
    output logic [31:0]              tcdm_r_data,
    output logic                     tcdm_r_valid,
    input  logic                     dbg_we,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    input  logic [31:0]              dbg_wdata,
    output logic [31:0]              dbg_rdata,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count,
    output logic                     err
);
    import aes_tcdm_resp_package::*;

    localparam int          c_AW        = $clog2(DEPTH);
    localparam logic [29:0] c_IDX_LIMIT = 30'(DEPTH);

    logic [31:0]     w_off;
    logic            w_in_range;
    logic [c_AW-1:0] w_idx;
    logic            w_stall;
    logic            w_rd_gnt;
    logic            w_wr_gnt;
    logic [31:0]     w_resp_data;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     dbg_rdata_q;
    logic [31:0]     rd_count_q;
    logic [31:0]     wr_count_q;
    logic            err_q;

    // Address decode: offset wraps modulo 2^32, so addresses below BASE_ADDR
    // land far outside the memory and are flagged invalid
    assign w_off      = tcdm_add - BASE_ADDR;
    assign w_in_range = (w_off[1:0] == 2'b00) && (w_off[31:2] < c_IDX_LIMIT);
    assign w_idx      = w_off[c_AW+1:2];

    assign tcdm_gnt   = tcdm_req & ~w_stall;
    assign w_rd_gnt   = tcdm_gnt &  tcdm_wen;
    assign w_wr_gnt   = tcdm_gnt & ~tcdm_wen;

    generate
        if (GNT_STALL_PERIOD > 0) begin : g_stall
            localparam int              c_SW   = (GNT_STALL_PERIOD > 1) ? $clog2(GNT_STALL_PERIOD) : 1;
            localparam logic [c_SW-1:0] c_LAST = c_SW'(GNT_STALL_PERIOD - 1);

            logic [c_SW-1:0] stall_cnt_q;
            logic [c_SW-1:0] stall_cnt_d;

            // Count request cycles (granted or not), wrapping after the stall slot
            always_comb begin
                stall_cnt_d = stall_cnt_q;
                if (tcdm_req) begin
                    stall_cnt_d = (stall_cnt_q == c_LAST) ? '0 : stall_cnt_q + 1'b1;
                end
            end

            // Stall counter register, cleared together with the statistics
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stall_cnt_q <= '0;
                end else if (clear) begin
                    stall_cnt_q <= '0;
                end else begin
                    stall_cnt_q <= stall_cnt_d;
                end
            end

            assign w_stall = (stall_cnt_q == c_LAST);
        end else begin : g_no_stall
            assign w_stall = 1'b0;
        end
    endgenerate

    // Memory writes; the TCDM write is last so it overrides a same-word backdoor write
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem_q[dbg_addr] <= dbg_wdata;
        end
        if (w_wr_gnt && w_in_range) begin
            mem_q[w_idx] <= be_merge(mem_q[w_idx], tcdm_data, tcdm_be);
        end
    end

    // Response payload captured at the grant edge: pre-edge memory word or error pattern
    always_comb begin
        w_resp_data = 32'h0;
        if (w_rd_gnt) begin
            w_resp_data = w_in_range ? mem_q[w_idx] : ERR_DATA;
        end
    end

    // Registered backdoor read of the pre-edge contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rdata_q <= 32'h0;
        end else begin
            dbg_rdata_q <= mem_q[dbg_addr];
        end
    end

    // Access statistics and sticky error; clear takes priority over same-cycle updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= 32'h0;
            wr_count_q <= 32'h0;
            err_q      <= 1'b0;
        end else if (clear) begin
            rd_count_q <= 32'h0;
            wr_count_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            if (w_rd_gnt) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (w_wr_gnt) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (tcdm_gnt && !w_in_range) begin
                err_q <= 1'b1;
            end
        end
    end

    aes_tcdm_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (clear),
        .in_valid_i  (tcdm_gnt),
        .in_data_i   (w_resp_data),
        .out_valid_o (tcdm_r_valid),
        .out_data_o  (tcdm_r_data)
    );

    assign dbg_rdata = dbg_rdata_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_tcdm_responder
// Description : Directed bench for aes_tcdm_responder. Three instances:
//               u0 defaults (LATENCY=1), u1 LATENCY=3 with GNT_STALL_PERIOD=3,
//               u2 LATENCY=2. Expected responses are queued at grant time and
//               matched by a per-cycle monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_tcdm_responder;

    localparam int          NI   = 3;
    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam logic [31:0] EDAT = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear     [NI];
    logic        req       [NI];
    logic        gnt       [NI];
    logic [31:0] add       [NI];
    logic        wen       [NI];
    logic [3:0]  be        [NI];
    logic [31:0] wdata     [NI];
    logic [31:0] rdata     [NI];
    logic        rvalid    [NI];
    logic        dbg_we    [NI];
    logic [9:0]  dbg_addr  [NI];
    logic [31:0] dbg_wdata [NI];
    logic [31:0] dbg_rdata [NI];
    logic [31:0] rd_cnt    [NI];
    logic [31:0] wr_cnt    [NI];
    logic        err       [NI];

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   mon_on = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        aes_tcdm_responder #(
            .DEPTH            (1024),
            .BASE_ADDR        (BASE),
            .LATENCY          ((k == 0) ? 1 : ((k == 1) ? 3 : 2)),
            .GNT_STALL_PERIOD ((k == 1) ? 3 : 0)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .clear        (clear[k]),
            .tcdm_req     (req[k]),
            .tcdm_gnt     (gnt[k]),
            .tcdm_add     (add[k]),
            .tcdm_wen     (wen[k]),
            .tcdm_be      (be[k]),
            .tcdm_data    (wdata[k]),
            .tcdm_r_data  (rdata[k]),
            .tcdm_r_valid (rvalid[k]),
            .dbg_we       (dbg_we[k]),
            .dbg_addr     (dbg_addr[k]),
            .dbg_wdata    (dbg_wdata[k]),
            .dbg_rdata    (dbg_rdata[k]),
            .rd_count     (rd_cnt[k]),
            .wr_count     (wr_cnt[k]),
            .err          (err[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_push(input int k, input logic [31:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic q_drop(input int k);
        exp_t e;
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic q_flush(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[u%0d]: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Response monitor: every negedge, r_valid must match the queue head's due cycle
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < NI; k++) begin
                logic exp_v;
                exp_t e;
                exp_v = 1'b0;
                if (q_size(k) > 0) begin
                    e     = q_front(k);
                    exp_v = (e.due <= cyc);
                end
                chk("r_valid", k, 32'(rvalid[k]), 32'(exp_v));
                if (exp_v) begin
                    q_drop(k);
                    chk("r_data", k, rdata[k], e.data);
                end else begin
                    chk("r_data_idle", k, rdata[k], 32'h0);
                end
            end
        end
    end

    // Present a request at a negedge, hold it until granted, then cross the grant edge
    task automatic issue(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] exp_d, output int waited);
        req[k]   = 1'b1;
        add[k]   = a;
        wen[k]   = w;
        be[k]    = b;
        wdata[k] = d;
        waited   = 0;
        #1;
        while (!gnt[k] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("gnt", k, 32'(gnt[k]), 32'h1);
        q_push(k, exp_d, cyc + lat_of(k));
        @(posedge clk);
        if (clear[k]) q_flush(k);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        req[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (q_size(k) > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", k, 32'(q_size(k)), 32'h0);
    endtask

    task automatic bd_write(input int k, input int idx, input logic [31:0] d);
        dbg_we[k]    = 1'b1;
        dbg_addr[k]  = 10'(idx);
        dbg_wdata[k] = d;
        @(posedge clk);
        @(negedge clk);
        dbg_we[k] = 1'b0;
    endtask

    task automatic bd_check(input int k, input int idx, input logic [31:0] exp, input string tag);
        dbg_addr[k] = 10'(idx);
        @(posedge clk);
        @(negedge clk);
        chk(tag, k, dbg_rdata[k], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int g;
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            clear[k] = 1'b0; req[k] = 1'b0; add[k] = 32'h0; wen[k] = 1'b1; be[k] = 4'h0;
            wdata[k] = 32'h0; dbg_we[k] = 1'b0; dbg_addr[k] = 10'h0; dbg_wdata[k] = 32'h0;
        end
        #2;
        // Reset state of all instances
        for (int k = 0; k < NI; k++) begin
            chk("rst_gnt",       k, 32'(gnt[k]),    32'h0);
            chk("rst_r_valid",   k, 32'(rvalid[k]), 32'h0);
            chk("rst_r_data",    k, rdata[k],       32'h0);
            chk("rst_dbg_rdata", k, dbg_rdata[k],   32'h0);
            chk("rst_rd_count",  k, rd_cnt[k],      32'h0);
            chk("rst_wr_count",  k, wr_cnt[k],      32'h0);
            chk("rst_err",       k, 32'(err[k]),    32'h0);
        end
        req[1] = 1'b1;
        #1;
        chk("rst_gnt_follows_req", 1, 32'(gnt[1]), 32'h1);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_on = 1'b1;

        // u0: backdoor load then TCDM read with single-cycle latency
        bd_write(0, 0, 32'h0011_2233);
        bd_check(0, 0, 32'h0011_2233, "dbg_rdata_w0");
        issue(0, BASE, 1'b1, 4'h0, 32'h0, 32'h0011_2233, w);
        chk("gnt_no_wait", 0, 32'(w), 32'h0);
        idle(0);
        drain(0);
        chk("rd_count_1", 0, rd_cnt[0], 32'd1);

        // u0: partial byte-enable write, read back on the next cycle
        bd_write(0, 1, 32'h0);
        issue(0, BASE + 32'h4, 1'b0, 4'b0101, 32'hAABB_CCDD, 32'h0, w);
        issue(0, BASE + 32'h4, 1'b1, 4'h0, 32'h0, 32'h00BB_00DD, w);
        idle(0);
        drain(0);
        chk("rd_count_2", 0, rd_cnt[0], 32'd2);
        chk("wr_count_1", 0, wr_cnt[0], 32'd1);

        // u0: backdoor and TCDM write to word 5 on the same edge
        bd_write(0, 5, 32'h1111_1111);
        dbg_we[0]    = 1'b1;
        dbg_addr[0]  = 10'd5;
        dbg_wdata[0] = 32'h2222_2222;
        issue(0, BASE + 32'h14, 1'b0, 4'hF, 32'h3333_3333, 32'h0, w);
        dbg_we[0] = 1'b0;
        idle(0);
        chk("dbg_old_value", 0, dbg_rdata[0], 32'h1111_1111);
        @(posedge clk);
        @(negedge clk);
        chk("dbg_tcdm_wins", 0, dbg_rdata[0], 32'h3333_3333);
        issue(0, BASE + 32'h14, 1'b1, 4'h0, 32'h0, 32'h3333_3333, w);
        idle(0);
        drain(0);
        chk("wr_count_2", 0, wr_cnt[0], 32'd2);

        // u1: grant stall pattern with GNT_STALL_PERIOD=3
        for (int i = 0; i < 6; i++) bd_write(1, 10 + i, 32'hC0DE_0000 + 32'(10 + i));
        bd_write(1, 0, 32'h5555_AAAA);
        g = 0;
        for (int i = 0; i < 9; i++) begin
            req[1] = 1'b1;
            wen[1] = 1'b1;
            add[1] = BASE + 32'(4 * (10 + g));
            #1;
            chk("gnt_pattern", 1, 32'(gnt[1]), 32'((i % 3) != 2));
            if (gnt[1]) begin
                q_push(1, 32'hC0DE_0000 + 32'(10 + g), cyc + 3);
                g++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        idle(1);
        drain(1);
        chk("stall_rd_count", 1, rd_cnt[1], 32'd6);
        chk("err_clean", 1, 32'(err[1]), 32'h0);

        // u1: misaligned read and out-of-range write
        issue(1, BASE + 32'h2, 1'b1, 4'h0, 32'h0, EDAT, w);
        issue(1, BASE + 32'h1000, 1'b0, 4'hF, 32'hFFFF_FFFF, 32'h0, w);
        idle(1);
        drain(1);
        chk("err_set",      1, 32'(err[1]), 32'h1);
        chk("inv_wr_count", 1, wr_cnt[1],   32'd1);
        chk("inv_rd_count", 1, rd_cnt[1],   32'd7);
        bd_check(1, 0, 32'h5555_AAAA, "mem_unchanged");

        // u2: address below base wraps to an invalid offset
        for (int i = 0; i < 4; i++) bd_write(2, 20 + i, 32'h0000_0100 + 32'(i));
        issue(2, BASE - 32'h4, 1'b1, 4'h0, 32'h0, EDAT, w);
        idle(2);
        drain(2);
        chk("err_below_base", 2, 32'(err[2]), 32'h1);

        // u2: clear flushes in-flight responses, including the one granted with it
        issue(2, BASE + 32'd80, 1'b1, 4'h0, 32'h0, 32'h0000_0100, w);
        issue(2, BASE + 32'd84, 1'b1, 4'h0, 32'h0, 32'h0000_0101, w);
        clear[2] = 1'b1;
        issue(2, BASE + 32'd96, 1'b0, 4'hF, 32'h7777_0000, 32'h0, w);
        clear[2] = 1'b0;
        idle(2);
        chk("clr_rd_count", 2, rd_cnt[2],   32'd0);
        chk("clr_wr_count", 2, wr_cnt[2],   32'd0);
        chk("clr_err",      2, 32'(err[2]), 32'h0);
        repeat (3) @(negedge clk);
        bd_check(2, 24, 32'h7777_0000, "clear_write_kept");
        bd_check(2, 20, 32'h0000_0100, "clear_mem_kept");
        issue(2, BASE + 32'd92, 1'b1, 4'h0, 32'h0, 32'h0000_0103, w);
        idle(2);
        drain(2);
        chk("post_clr_rd", 2, rd_cnt[2], 32'd1);

        for (int k = 0; k < NI; k++) drain(k);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
